// File: rtl/multicycle_control_if.sv
// Signal bundle between the multicycle sequencer and the IR/decoder + datapath.
// Defining INSTR_COUNT_EN adds the retired-instruction count to the bundle.
interface multicycle_control_if #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                is_zero;
  logic                mem_ready;
  logic                resume;
  logic                pc_en;
  logic                pc_load;
  logic                pc_skip;
  logic                acc_load;
  logic [1:0]          acc_sel;
  logic                mem_ins_en;
  logic                mem_da_en;
  logic                mem_da_we;
  logic                jmp;
  logic                halt;
  logic                err;
  logic [2:0]          state_o;
`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0]    retired;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("multicycle_control_if: CNT_W must be at least 1");
  end

  // master is the sequencer; slave is the decoder/datapath side
  modport master (
`ifdef INSTR_COUNT_EN
    output retired,
`endif
    input  opcode, is_zero, mem_ready, resume,
    output pc_en, pc_load, pc_skip, acc_load, acc_sel,
    output mem_ins_en, mem_da_en, mem_da_we, jmp, halt, err, state_o
  );

  modport slave (
`ifdef INSTR_COUNT_EN
    input  retired,
`endif
    output opcode, is_zero, mem_ready, resume,
    input  pc_en, pc_load, pc_skip, acc_load, acc_sel,
    input  mem_ins_en, mem_da_en, mem_da_we, jmp, halt, err, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with memory-ready timeout
// and resumable halt. Defining INSTR_COUNT_EN adds a retired-instruction counter.
module multicycle_control #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  // NOP gets its own code so that a resume can force it even when OPCODE_W is 3
  typedef enum logic [3:0] {
    OP_HLT = 4'd0,
    OP_SKZ = 4'd1,
    OP_ADD = 4'd2,
    OP_AND = 4'd3,
    OP_XOR = 4'd4,
    OP_LDA = 4'd5,
    OP_STO = 4'd6,
    OP_JMP = 4'd7,
    OP_NOP = 4'd8
  } op_e;

  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

  if (OPCODE_W < 3 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_control: illegal parameter combination");
  end

  state_e              state_q, state_d;
  op_e                 ir_op_q, ir_op_d;
  logic [7:0]          wait_q, wait_d;
  logic                err_q, err_d;
  logic [OPCODE_W-1:0] opcode_in;
  op_e                 dec_op;
  logic                is_mem_op;

  assign opcode_in = bus.opcode;

  // Codes above 7 all collapse onto NOP
  always_comb begin
    dec_op = op_e'({1'b0, opcode_in[2:0]});
    if (|(opcode_in >> 3)) begin
      dec_op = OP_NOP;
    end
  end

  assign is_mem_op = (ir_op_q == OP_ADD) || (ir_op_q == OP_AND) || (ir_op_q == OP_XOR) ||
                     (ir_op_q == OP_LDA) || (ir_op_q == OP_STO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_op_q <= OP_HLT;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_op_q <= ir_op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_op_d = ir_op_q;
    wait_d  = 8'd0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_op_d = dec_op;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_mem_op) begin
          // A ready arriving on the final allowed cycle still completes the access
          if (bus.mem_ready) begin
            state_d = S_WRITEBACK;
          end else if (wait_q == LastWait) begin
            state_d = S_HALTED;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else if (ir_op_q == OP_HLT) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALTED: begin
        if (bus.resume && !err_q) begin
          state_d = S_WRITEBACK;
          ir_op_d = OP_NOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.pc_load    = 1'b0;
    bus.pc_skip    = 1'b0;
    bus.acc_load   = 1'b0;
    bus.acc_sel    = 2'd0;
    bus.mem_ins_en = 1'b0;
    bus.mem_da_en  = 1'b0;
    bus.mem_da_we  = 1'b0;
    bus.jmp        = 1'b0;
    bus.halt       = 1'b0;
    unique case (state_q)
      S_FETCH, S_DECODE: bus.mem_ins_en = 1'b1;
      S_EXECUTE: begin
        bus.mem_ins_en = 1'b1;
        bus.mem_da_en  = is_mem_op;
        bus.mem_da_we  = (ir_op_q == OP_STO);
        bus.jmp        = (ir_op_q == OP_JMP);
      end
      S_WRITEBACK: begin
        bus.pc_en = 1'b1;
        case (ir_op_q)
          OP_ADD: begin bus.acc_load = 1'b1; bus.acc_sel = 2'd0; end
          OP_AND: begin bus.acc_load = 1'b1; bus.acc_sel = 2'd1; end
          OP_XOR: begin bus.acc_load = 1'b1; bus.acc_sel = 2'd2; end
          OP_LDA: begin bus.acc_load = 1'b1; bus.acc_sel = 2'd3; end
          OP_SKZ: bus.pc_skip = bus.is_zero;
          OP_JMP: begin
            bus.pc_en   = 1'b0;
            bus.pc_load = 1'b1;
            bus.jmp     = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALTED: bus.halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.err     = err_q;
  assign bus.state_o = state_q;

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (state_q == S_WRITEBACK) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, hand-built corner
// sequences and randomized instruction streams checked against an instruction-level model.
module tb_multicycle_control;

  localparam int OPC_W   = 4;
  localparam int TIMEOUT = 4;

  localparam logic [11:0] O_PCEN = 12'h800;
  localparam logic [11:0] O_PCLD = 12'h400;
  localparam logic [11:0] O_SKIP = 12'h200;
  localparam logic [11:0] O_ACC  = 12'h100;
  localparam logic [11:0] O_INS  = 12'h020;
  localparam logic [11:0] O_DA   = 12'h010;
  localparam logic [11:0] O_WE   = 12'h008;
  localparam logic [11:0] O_JMP  = 12'h004;
  localparam logic [11:0] O_HALT = 12'h002;
  localparam logic [11:0] O_ERR  = 12'h001;

  typedef struct {
    logic             rst;
    logic [OPC_W-1:0] opcode;
    logic             isZero;
    logic             memReady;
    logic             resume;
    logic             chk;
    logic [2:0]       expState;
    logic [11:0]      expOut;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;
  bit   errFlag    = 1'b0;
  int   expRetired = 0;
  vec_t vq[$];

  multicycle_control_if #(.OPCODE_W(OPC_W), .CNT_W(16)) bus ();

  multicycle_control #(.OPCODE_W(OPC_W), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, int opc, bit z, bit mr, bit res, bit c, int st,
                              logic [11:0] o);
    vec_t v;
    v.rst = r; v.opcode = OPC_W'(opc); v.isZero = z; v.memReady = mr; v.resume = res;
    v.chk = c; v.expState = 3'(st); v.expOut = o;
    return v;
  endfunction

  // Expected outputs for a phase (0 idle .. 5 halted) and effective opcode (8 = NOP)
  function automatic logic [11:0] phaseOut(int phase, int op, bit z, bit e);
    logic [11:0] o;
    bit memOp;
    o = '0;
    memOp = (op >= 2 && op <= 6);
    case (phase)
      1, 2: o = O_INS;
      3: begin
        o = O_INS;
        if (memOp) o |= O_DA;
        if (op == 6) o |= O_WE;
        if (op == 7) o |= O_JMP;
      end
      4: begin
        o = (op == 7) ? (O_PCLD | O_JMP) : O_PCEN;
        if (op >= 2 && op <= 5) o |= O_ACC | (12'(op - 2) << 6);
        if (op == 1 && z) o |= O_SKIP;
      end
      5: o = O_HALT;
      default: o = '0;
    endcase
    if (e) o |= O_ERR;
    return o;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int rop();
    return int'($urandom_range(0, 15));
  endfunction

  task automatic push(bit r, int phase, int op, int opc, bit z, bit mr, bit res);
    vq.push_back(mk(r, opc, z, mr, res, !r, phase, phaseOut(phase, op, z, errFlag)));
  endtask

  task automatic genReset();
    push(1'b1, 0, 0, rop(), rb(), rb(), rb());
    errFlag = 1'b0;
    push(1'b0, 0, 0, rop(), rb(), rb(), rb());
  endtask

  // One instruction from FETCH; w = cycles mem_ready stays low, h = halted cycles before resume
  task automatic genInstr(int opc, int w, bit z, int h, output bit stuck);
    int op;
    bit memOp;
    bit mr;
    op = (opc > 7) ? 8 : opc;
    memOp = (op >= 2 && op <= 6);
    stuck = 1'b0;
    push(1'b0, 1, op, rop(), rb(), rb(), rb());
    push(1'b0, 2, op, opc, rb(), rb(), rb());
    if (memOp) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        mr = (k >= w);
        push(1'b0, 3, op, rop(), rb(), mr, rb());
        if (mr) break;
      end
      if (w >= TIMEOUT) begin
        errFlag = 1'b1;
        stuck = 1'b1;
        return;
      end
    end else begin
      push(1'b0, 3, op, rop(), rb(), rb(), rb());
      if (op == 0) begin
        for (int k = 0; k < h; k++) push(1'b0, 5, op, rop(), rb(), rb(), (k == h - 1));
        op = 8;
      end
    end
    push(1'b0, 4, op, rop(), z, rb(), rb());
  endtask

  task automatic holdStuck(int n);
    for (int k = 0; k < n; k++) push(1'b0, 5, 0, rop(), rb(), rb(), (k % 2 == 0));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst           = v.rst;
    bus.opcode    = v.opcode;
    bus.is_zero   = v.isZero;
    bus.mem_ready = v.memReady;
    bus.resume    = v.resume;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [11:0] got;
    if (!v.chk) return;
    got = {bus.pc_en, bus.pc_load, bus.pc_skip, bus.acc_load, bus.acc_sel, bus.mem_ins_en,
           bus.mem_da_en, bus.mem_da_we, bus.jmp, bus.halt, bus.err};
    checkCount++;
    if (bus.state_o !== v.expState) begin
      failCount++;
      $display("[TB] FAIL state vec=%0d got=%0d want=%0d", idx, bus.state_o, v.expState);
    end
    checkCount++;
    if (got !== v.expOut) begin
      failCount++;
      $display("[TB] FAIL outputs vec=%0d got=%03h want=%03h", idx, got, v.expOut);
    end
`ifdef INSTR_COUNT_EN
    checkCount++;
    if (bus.retired !== 16'(expRetired)) begin
      failCount++;
      $display("[TB] FAIL retired vec=%0d got=%0d want=%0d", idx, bus.retired, expRetired);
    end
`endif
  endtask

  initial begin
    vec_t table0[26];
    bit   stuck;
    int   opc, w, h;
    bit   z;

    // reset, ADD, SKZ taken/not taken, JMP, XOR, wide-code NOP
    table0[0]  = mk(1, 0, 0, 0, 0, 0, 0, '0);
    table0[1]  = mk(0, 0, 0, 0, 0, 1, 0, '0);
    table0[2]  = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[3]  = mk(0, 2, 0, 0, 0, 1, 2, O_INS);
    table0[4]  = mk(0, 0, 0, 1, 0, 1, 3, O_INS | O_DA);
    table0[5]  = mk(0, 0, 0, 0, 0, 1, 4, O_PCEN | O_ACC);
    table0[6]  = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[7]  = mk(0, 1, 0, 0, 0, 1, 2, O_INS);
    table0[8]  = mk(0, 0, 0, 0, 0, 1, 3, O_INS);
    table0[9]  = mk(0, 0, 1, 0, 0, 1, 4, O_PCEN | O_SKIP);
    table0[10] = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[11] = mk(0, 1, 0, 0, 0, 1, 2, O_INS);
    table0[12] = mk(0, 0, 0, 0, 0, 1, 3, O_INS);
    table0[13] = mk(0, 0, 0, 0, 0, 1, 4, O_PCEN);
    table0[14] = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[15] = mk(0, 7, 0, 0, 0, 1, 2, O_INS);
    table0[16] = mk(0, 0, 0, 0, 0, 1, 3, O_INS | O_JMP);
    table0[17] = mk(0, 0, 1, 0, 0, 1, 4, O_PCLD | O_JMP);
    table0[18] = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[19] = mk(0, 4, 0, 0, 0, 1, 2, O_INS);
    table0[20] = mk(0, 0, 0, 1, 0, 1, 3, O_INS | O_DA);
    table0[21] = mk(0, 0, 0, 0, 0, 1, 4, O_PCEN | O_ACC | 12'h080);
    table0[22] = mk(0, 0, 0, 0, 0, 1, 1, O_INS);
    table0[23] = mk(0, 9, 0, 0, 0, 1, 2, O_INS);
    table0[24] = mk(0, 0, 0, 0, 0, 1, 3, O_INS);
    table0[25] = mk(0, 0, 1, 0, 1, 1, 4, O_PCEN);
    for (int i = 0; i < 26; i++) vq.push_back(table0[i]);

    // STO with three wait cycles, HLT held then resumed, LDA timeout then reset
    genInstr(6, 3, 1'b0, 1, stuck);
    genInstr(0, 0, 1'b0, 11, stuck);
    genInstr(5, 99, 1'b0, 1, stuck);
    holdStuck(6);
    genReset();

    for (int n = 0; n < 60; n++) begin
      opc = rop();
      w   = int'($urandom_range(0, 4));
      h   = int'($urandom_range(1, 4));
      z   = rb();
      genInstr(opc, w, z, h, stuck);
      if (stuck) begin
        holdStuck(int'($urandom_range(1, 4)));
        genReset();
      end
    end

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i]);
      #1;
      checkOutput(vq[i], i);
      if (vq[i].rst) expRetired = 0;
      else if (vq[i].expState == 3'd4) expRetired++;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
